timer_multichannel: RTL and testbench



---
 rtl/timer_multichannel.sv | 156 +++++++++++++++
 tb/tb_timer_multichannel.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/timer_multichannel.sv
// Multichannel compare timer: one prescaled up-counter shared by CHANNELS
// compare channels, each in toggle-on-match or PWM mode, with one-shot
// support, W1C status flags and a level interrupt.
module timer_multichannel #(
   parameter int WIDTH           = 16,
   parameter int CHANNELS        = 4,
   parameter int PRESCALER_WIDTH = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [4:0]          bus_addr,
   input  logic                bus_we,
   input  logic [31:0]         bus_wdata,
   output logic [31:0]         bus_rdata,
   output logic [CHANNELS-1:0] cmp_out,
   output logic                irq
);

   localparam logic [4:0] ADDR_CTRL   = 5'd0;
   localparam logic [4:0] ADDR_PRESC  = 5'd1;
   localparam logic [4:0] ADDR_TOP    = 5'd2;
   localparam logic [4:0] ADDR_COUNT  = 5'd3;
   localparam logic [4:0] ADDR_STATUS = 5'd4;
   localparam logic [4:0] ADDR_IRQEN  = 5'd5;
   localparam int         ADDR_CMP    = 8;

   logic                       en, oneshot, pwm;
   logic [PRESCALER_WIDTH-1:0] presc, pre_cnt;
   logic [WIDTH-1:0]           top, count;
   logic [WIDTH-1:0]           cmp [CHANNELS];
   logic [CHANNELS:0]          status, irqen, status_set, status_clr, status_next;

   logic wr_ctrl, wr_presc, wr_top, wr_count, wr_status, wr_irqen;
   logic tick, cnt_tick, wrap;

   assign wr_ctrl   = bus_we && (bus_addr == ADDR_CTRL);
   assign wr_presc  = bus_we && (bus_addr == ADDR_PRESC);
   assign wr_top    = bus_we && (bus_addr == ADDR_TOP);
   assign wr_count  = bus_we && (bus_addr == ADDR_COUNT);
   assign wr_status = bus_we && (bus_addr == ADDR_STATUS);
   assign wr_irqen  = bus_we && (bus_addr == ADDR_IRQEN);

   // A bus write to COUNT overrides the tick entirely: no count step, no
   // overflow, no compare event from that cycle.
   assign tick     = en && (pre_cnt == presc);
   assign cnt_tick = tick && !wr_count;
   assign wrap     = cnt_tick && (count == top);

   // Hardware flag sets, W1C clears, and the resulting next status (set wins)
   always_comb begin
      status_set    = '0;
      status_set[0] = wrap;
      for (int i = 0; i < CHANNELS; i++)
         status_set[i+1] = cnt_tick && (count == cmp[i]);
      status_clr  = wr_status ? bus_wdata[CHANNELS:0] : '0;
      status_next = (status & ~status_clr) | status_set;
   end

   // Control register; a bus write beats the one-shot EN clear
   always_ff @(posedge clk) begin
      if (reset) begin
         en      <= 1'b0;
         oneshot <= 1'b0;
         pwm     <= 1'b0;
      end else if (wr_ctrl) begin
         en      <= bus_wdata[0];
         oneshot <= bus_wdata[1];
         pwm     <= bus_wdata[2];
      end else if (wrap && oneshot) begin
         en      <= 1'b0;
      end
   end

   // Configuration registers: PRESC, TOP, IRQEN and the compare values
   always_ff @(posedge clk) begin
      if (reset) begin
         presc <= '0;
         top   <= '1;
         irqen <= '0;
         for (int i = 0; i < CHANNELS; i++)
            cmp[i] <= '0;
      end else begin
         if (wr_presc) presc <= bus_wdata[PRESCALER_WIDTH-1:0];
         if (wr_top)   top   <= bus_wdata[WIDTH-1:0];
         if (wr_irqen) irqen <= bus_wdata[CHANNELS:0];
         for (int i = 0; i < CHANNELS; i++)
            if (bus_we && (bus_addr == 5'(ADDR_CMP + i)))
               cmp[i] <= bus_wdata[WIDTH-1:0];
      end
   end

   // Prescaler: frozen (not cleared) while EN is low
   always_ff @(posedge clk) begin
      if (reset)
         pre_cnt <= '0;
      else if (en)
         pre_cnt <= (pre_cnt == presc) ? '0 : pre_cnt + 1'b1;
   end

   // Main counter; a TOP written below COUNT lets it run through all-ones
   // and wrap naturally without flagging an overflow
   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (wr_count)
         count <= bus_wdata[WIDTH-1:0];
      else if (wrap)
         count <= '0;
      else if (cnt_tick)
         count <= count + 1'b1;
   end

   // Status flags and the registered interrupt level
   always_ff @(posedge clk) begin
      if (reset) begin
         status <= '0;
         irq    <= 1'b0;
      end else begin
         status <= status_next;
         irq    <= |(status_next & irqen);
      end
   end

   // Compare outputs: PWM level every cycle, or toggle on a compare match
   always_ff @(posedge clk) begin
      if (reset) begin
         cmp_out <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (pwm)
               cmp_out[i] <= (count < cmp[i]);
            else if (status_set[i+1])
               cmp_out[i] <= ~cmp_out[i];
         end
      end
   end

   // Register read-back, zero-extended; unmapped addresses read 0
   always_comb begin
      bus_rdata = '0;
      case (bus_addr)
         ADDR_CTRL:   bus_rdata[2:0] = {pwm, oneshot, en};
         ADDR_PRESC:  bus_rdata[PRESCALER_WIDTH-1:0] = presc;
         ADDR_TOP:    bus_rdata[WIDTH-1:0] = top;
         ADDR_COUNT:  bus_rdata[WIDTH-1:0] = count;
         ADDR_STATUS: bus_rdata[CHANNELS:0] = status;
         ADDR_IRQEN:  bus_rdata[CHANNELS:0] = irqen;
         default: begin
            for (int i = 0; i < CHANNELS; i++)
               if (bus_addr == 5'(ADDR_CMP + i))
                  bus_rdata[WIDTH-1:0] = cmp[i];
         end
      endcase
   end

endmodule

// File: tb/tb_timer_multichannel.sv
// Bench for timer_multichannel (WIDTH=16, CHANNELS=4, PRESCALER_WIDTH=16):
// table of register write/read-back vectors plus hand-timed sequences.
module tb_timer_multichannel;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [4:0]  bus_addr = '0;
   logic        bus_we = 1'b0;
   logic [31:0] bus_wdata = '0;
   logic [31:0] bus_rdata;
   logic [3:0]  cmp_out;
   logic        irq;

   int n_cmp = 0;
   int n_fail = 0;

   timer_multichannel #(.WIDTH(16), .CHANNELS(4), .PRESCALER_WIDTH(16)) dut (
      .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_we(bus_we),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .cmp_out(cmp_out), .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [11];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Called at a negedge; the write lands on the following posedge.
   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      bus_addr  = a;
      bus_wdata = d;
      bus_we    = 1'b1;
      @(negedge clk);
      bus_we    = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a, output logic [31:0] v);
      bus_addr = a;
      #1;
      v = bus_rdata;
   endtask

   task automatic chk_reg(input string nm, input logic [4:0] a, input logic [31:0] exp);
      logic [31:0] v;
      rd(a, v);
      chk(nm, v, exp);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int ones0, ones1, ones2, ones3;
      logic [31:0] v;

      tbl[0]  = '{"ctrl_trunc",   5'd0,  32'hFFFF_FFF8, 32'h0};
      tbl[1]  = '{"presc_trunc",  5'd1,  32'h0001_2345, 32'h2345};
      tbl[2]  = '{"top_trunc",    5'd2,  32'h000A_BCDE, 32'hBCDE};
      tbl[3]  = '{"count_wr",     5'd3,  32'hFFFF_1234, 32'h1234};
      tbl[4]  = '{"irqen_trunc",  5'd5,  32'hFFFF_FFFF, 32'h1F};
      tbl[5]  = '{"cmp0_trunc",   5'd8,  32'h0001_0005, 32'h5};
      tbl[6]  = '{"cmp3_wr",      5'd11, 32'h0000_FFFF, 32'hFFFF};
      tbl[7]  = '{"unmapped6",    5'd6,  32'hDEAD_BEEF, 32'h0};
      tbl[8]  = '{"unmapped12",   5'd12, 32'h0000_0055, 32'h0};
      tbl[9]  = '{"unmapped31",   5'd31, 32'h0000_0001, 32'h0};
      tbl[10] = '{"status_w1c0",  5'd4,  32'hFFFF_FFFF, 32'h0};

      @(negedge clk);

      // 1. reset with a concurrent CTRL write
      reset = 1'b1; bus_we = 1'b1; bus_addr = 5'd0; bus_wdata = 32'd7;
      repeat (2) @(negedge clk);
      reset = 1'b0; bus_we = 1'b0;
      chk_reg("rst_ctrl",   5'd0, 32'h0);
      chk_reg("rst_presc",  5'd1, 32'h0);
      chk_reg("rst_top",    5'd2, 32'hFFFF);
      chk_reg("rst_count",  5'd3, 32'h0);
      chk_reg("rst_status", 5'd4, 32'h0);
      chk_reg("rst_irqen",  5'd5, 32'h0);
      chk_reg("rst_cmp0",   5'd8, 32'h0);
      chk("rst_cmp_out", {28'h0, cmp_out}, 32'h0);
      chk("rst_irq", {31'h0, irq}, 32'h0);

      // register access table (timer disabled throughout)
      for (int k = 0; k < 11; k++) begin
         wr(tbl[k].addr, tbl[k].wdata);
         chk_reg(tbl[k].name, tbl[k].addr, tbl[k].exp);
      end
      do_reset();

      // 2. prescaler, overflow, irq
      wr(5'd1, 32'd2);
      wr(5'd2, 32'd4);
      wr(5'd5, 32'd1);
      wr(5'd0, 32'd1);
      repeat (2) @(negedge clk);
      chk_reg("psc_count_e2", 5'd3, 32'd0);
      @(negedge clk);
      chk_reg("psc_count_e3", 5'd3, 32'd1);
      chk("psc_irq_low", {31'h0, irq}, 32'h0);
      repeat (11) @(negedge clk);
      chk_reg("psc_count_e14", 5'd3, 32'd4);
      rd(5'd4, v);
      chk("psc_ovf_e14", v & 32'h1, 32'h0);
      @(negedge clk);
      chk_reg("psc_count_e15", 5'd3, 32'd0);
      rd(5'd4, v);
      chk("psc_ovf_e15", v & 32'h1, 32'h1);
      @(negedge clk);
      chk("psc_irq_high", {31'h0, irq}, 32'h1);
      wr(5'd4, 32'd1);
      rd(5'd4, v);
      chk("psc_ovf_clr", v & 32'h1, 32'h0);
      @(negedge clk);
      chk("psc_irq_drop", {31'h0, irq}, 32'h0);
      do_reset();

      // 3. toggle mode
      wr(5'd2, 32'd9);
      wr(5'd8, 32'd3);
      wr(5'd9, 32'd7);
      wr(5'd10, 32'hFFFF);
      wr(5'd11, 32'hFFFF);
      wr(5'd0, 32'd1);
      for (int k = 1; k <= 18; k++) begin
         @(negedge clk);
         if (k == 3)  chk("tog_e3",  {28'h0, cmp_out}, 32'h0);
         if (k == 4)  chk("tog_e4",  {28'h0, cmp_out}, 32'h1);
         if (k == 7)  chk("tog_e7",  {28'h0, cmp_out}, 32'h1);
         if (k == 8)  chk("tog_e8",  {28'h0, cmp_out}, 32'h3);
         if (k == 14) chk("tog_e14", {28'h0, cmp_out}, 32'h2);
         if (k == 18) chk("tog_e18", {28'h0, cmp_out}, 32'h0);
      end
      chk_reg("tog_status", 5'd4, 32'h7);
      do_reset();

      // 4. PWM mode
      wr(5'd2, 32'd9);
      wr(5'd8, 32'd3);
      wr(5'd9, 32'd0);
      wr(5'd10, 32'd12);
      wr(5'd11, 32'hFFFF);
      wr(5'd0, 32'd5);
      ones0 = 0; ones1 = 0; ones2 = 0; ones3 = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         ones0 += int'(cmp_out[0]);
         ones1 += int'(cmp_out[1]);
         ones2 += int'(cmp_out[2]);
         ones3 += int'(cmp_out[3]);
         if (k == 1)  chk("pwm_e1",  {28'h0, cmp_out}, 32'hD);
         if (k == 4)  chk("pwm_e4",  {28'h0, cmp_out}, 32'hC);
         if (k == 11) chk("pwm_e11", {28'h0, cmp_out}, 32'hD);
      end
      chk("pwm_ch0_duty", 32'(ones0), 32'd6);
      chk("pwm_ch1_zero", 32'(ones1), 32'd0);
      chk("pwm_ch2_one",  32'(ones2), 32'd20);
      chk("pwm_ch3_one",  32'(ones3), 32'd20);
      do_reset();

      // 5. one-shot
      wr(5'd2, 32'd5);
      wr(5'd0, 32'd3);
      repeat (5) @(negedge clk);
      chk_reg("os_count_e5", 5'd3, 32'd5);
      chk_reg("os_ctrl_e5", 5'd0, 32'd3);
      @(negedge clk);
      chk_reg("os_count_e6", 5'd3, 32'd0);
      chk_reg("os_ctrl_e6", 5'd0, 32'd2);
      rd(5'd4, v);
      chk("os_ovf", v & 32'h1, 32'h1);
      wr(5'd4, 32'd1);
      repeat (20) @(negedge clk);
      rd(5'd4, v);
      chk("os_no_2nd_ovf", v & 32'h1, 32'h0);
      chk_reg("os_count_frozen", 5'd3, 32'd0);
      chk_reg("os_ctrl_final", 5'd0, 32'd2);
      do_reset();

      // 6. collisions
      wr(5'd2, 32'd4);
      wr(5'd0, 32'd1);
      repeat (4) @(negedge clk);
      chk_reg("col_count_top", 5'd3, 32'd4);
      wr(5'd3, 32'd2);
      chk_reg("col_count_wr", 5'd3, 32'd2);
      rd(5'd4, v);
      chk("col_no_ovf", v & 32'h1, 32'h0);
      repeat (2) @(negedge clk);
      chk_reg("col_count_4", 5'd3, 32'd4);
      wr(5'd4, 32'd1);
      rd(5'd4, v);
      chk("col_set_wins", v & 32'h1, 32'h1);
      wr(5'd0, 32'd0);
      wr(5'd4, 32'd1);
      rd(5'd4, v);
      chk("col_clear_ok", v & 32'h1, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
